// File: rtl/dpu.sv
// Display processing unit: saturates a binary value to 9999, converts it to BCD
// and drives one selected digit as a registered active-low 7-segment pattern.
module dpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic [1:0]  dsel,
    output logic [7:0]  seg,
    output logic [7:0]  dout
);

    logic [13:0] w_sat;
    logic [15:0] w_bcd;
    logic [29:0] w_dd;
    logic [3:0]  w_digit;
    logic [7:0]  w_seg;
    logic [15:0] r_bcd;

    assign w_sat = (din > 16'd9999) ? 14'd9999 : din[13:0];

    // Double dabble: 14 shift steps, correcting each BCD nibble before every shift.
    always_comb begin
        w_dd = {16'd0, w_sat};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (w_dd[14 + 4*d +: 4] >= 4'd5) begin
                    w_dd[14 + 4*d +: 4] = w_dd[14 + 4*d +: 4] + 4'd3;
                end
            end
            w_dd = w_dd << 1;
        end
        w_bcd = w_dd[29:14];
    end

    always_comb begin
        w_digit = 4'd0;
        case (dsel)
            2'd0:    w_digit = r_bcd[3:0];
            2'd1:    w_digit = r_bcd[7:4];
            2'd2:    w_digit = r_bcd[11:8];
            default: w_digit = r_bcd[15:12];
        endcase
    end

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is held off.
    always_comb begin
        w_seg = 8'hFF;
        case (w_digit)
            4'd0:    w_seg = 8'hC0;
            4'd1:    w_seg = 8'hF9;
            4'd2:    w_seg = 8'hA4;
            4'd3:    w_seg = 8'hB0;
            4'd4:    w_seg = 8'h99;
            4'd5:    w_seg = 8'h92;
            4'd6:    w_seg = 8'h82;
            4'd7:    w_seg = 8'hF8;
            4'd8:    w_seg = 8'h80;
            4'd9:    w_seg = 8'h90;
            default: w_seg = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd <= 16'd0;
            dout  <= 8'h00;
            seg   <= 8'hFF;
        end else begin
            r_bcd <= w_bcd;
            dout  <= {4'd0, w_digit};
            seg   <= w_seg;
        end
    end

endmodule

// File: tb/tb_dpu.sv
// Directed self-checking bench for dpu: reset, digit select, sweep,
// saturation and latency behaviour against hand-computed expectations.
module tb_dpu;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [1:0]  dsel;
    logic [7:0]  seg;
    logic [7:0]  dout;

    int n_cmp;
    int n_mis;
    logic [7:0] seg_tbl [10];

    dpu u_dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dsel (dsel),
        .seg  (seg),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_digit(input string tag, input int digit);
        chk({tag, "_dout"}, dout, 8'(digit));
        chk({tag, "_seg"}, seg, seg_tbl[digit]);
    endtask

    // Holds din for two edges, then walks dsel 0..3 checking each digit.
    task automatic show_all(input string tag, input logic [15:0] v, input int d3,
                            input int d2, input int d1, input int d0);
        int exp_d [4];
        exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
        din = v;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            dsel = 2'(s);
            tick();
            chk_digit($sformatf("%s_d%0d", tag, s), exp_d[s]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        seg_tbl[0] = 8'hC0; seg_tbl[1] = 8'hF9; seg_tbl[2] = 8'hA4; seg_tbl[3] = 8'hB0;
        seg_tbl[4] = 8'h99; seg_tbl[5] = 8'h92; seg_tbl[6] = 8'h82; seg_tbl[7] = 8'hF8;
        seg_tbl[8] = 8'h80; seg_tbl[9] = 8'h90;

        // Reset without any clock edge
        rst  = 1'b1;
        din  = 16'd0;
        dsel = 2'd0;
        #2;
        chk("rst_dout", dout, 8'h00);
        chk("rst_seg", seg, 8'hFF);
        rst = 1'b0;
        tick();
        chk("post_rst_dout", dout, 8'h00);
        chk("post_rst_seg", seg, 8'hC0);

        // Mid-operation reset discards the loaded value
        din = 16'd1234;
        tick();
        tick();
        chk_digit("pre_mid_rst", 4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_seg", seg, 8'hFF);
        #1;
        rst  = 1'b0;
        dsel = 2'd3;
        tick();
        chk_digit("rst_edge1", 0);
        tick();
        chk_digit("rst_edge2", 1);

        // Digit select with din=1000, two edges per step
        din = 16'd1000;
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            dsel = 2'(s);
            tick();
            tick();
            chk_digit($sformatf("sel1000_%0d", s), (s == 3) ? 1 : 0);
        end

        // Sweep 0..1000 in steps of 100
        for (int v = 0; v <= 1000; v += 100) begin
            show_all($sformatf("sweep%0d", v), 16'(v), (v / 1000) % 10,
                     (v / 100) % 10, (v / 10) % 10, v % 10);
        end

        // Other digit positions
        show_all("v4321", 16'd4321, 4, 3, 2, 1);
        show_all("v9876", 16'd9876, 9, 8, 7, 6);
        show_all("v5050", 16'd5050, 5, 0, 5, 0);
        show_all("v0007", 16'd7, 0, 0, 0, 7);

        // Saturation
        show_all("satFFFF", 16'hFFFF, 9, 9, 9, 9);
        show_all("sat10000", 16'd10000, 9, 9, 9, 9);
        show_all("sat9999", 16'd9999, 9, 9, 9, 9);
        show_all("v9998", 16'd9998, 9, 9, 9, 8);

        // Latency: din change takes two edges, dsel change one
        dsel = 2'd0;
        din  = 16'd123;
        tick();
        tick();
        chk_digit("lat_123", 3);
        din = 16'd456;
        tick();
        chk_digit("lat_edge1", 3);
        tick();
        chk_digit("lat_edge2", 6);
        tick();
        chk_digit("lat_edge3", 6);
        dsel = 2'd2;
        tick();
        chk_digit("lat_dsel", 4);

        // din and dsel change together: new dsel on old BCD, then on new BCD
        dsel = 2'd1;
        din  = 16'd789;
        tick();
        chk_digit("same_edge1", 5);
        tick();
        chk_digit("same_edge2", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
